// File: rtl/approx_mult_if.sv
// Operand/result handshake bundle for approx_mult_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface approx_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic [2*WIDTH-1:0]   err;
  logic                 out_mode;

  modport master (
    output in_valid, x, y, mode, out_ready,
    input  in_ready, out_valid, z, err, out_mode
  );

  modport slave (
    input  in_valid, x, y, mode, out_ready,
    output in_ready, out_valid, z, err, out_mode
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Pipelined WIDTH x WIDTH unsigned approximate multiplier
// with per-transaction exact/approximate mode and error stats.
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int TRUNC_COLS  = 6,
  parameter int APPROX_COLS = 8,
  parameter int STAGES      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  approx_mult_if.slave     bus,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] inexact_cnt
);
  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic [PW-1:0] z;
    logic [PW-1:0] err;
    logic          mode;
  } res_t;

  logic [PW-1:0]     exact;
  logic [PW-1:0]     approx;
  res_t              res_in;
  res_t              st [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] rdy;
  logic              out_fire;

  assign exact = PW'(bus.x) * PW'(bus.y);

  always_comb begin : col_model
    logic [PW-1:0]    csum;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic             pend;
    logic             pbit;
    logic             b;
    approx = '0;
    csum   = '0;
    xs     = '0;
    ys     = '0;
    pend   = 1'b0;
    pbit   = 1'b0;
    b      = 1'b0;
    for (int c = 0; c < PW; c++) begin
      csum = '0;
      pend = 1'b0;
      pbit = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (c - i >= 0 && c - i < WIDTH) begin
          xs = bus.x >> i;
          ys = bus.y >> (c - i);
          b  = xs[0] & ys[0];
          if (c >= APPROX_COLS) begin
            csum = csum + PW'(b);
          end else if (c >= TRUNC_COLS) begin
            // rows ascending; pairs collapse to a single OR bit
            if (pend) begin
              csum = csum + PW'(pbit | b);
              pend = 1'b0;
            end else begin
              pbit = b;
              pend = 1'b1;
            end
          end
        end
      end
      if (pend) begin
        csum = csum + PW'(pbit);
      end
      approx = approx + (csum << c);
    end
  end

  always_comb begin
    res_in      = '0;
    res_in.mode = bus.mode;
    res_in.z    = bus.mode ? approx : exact;
    res_in.err  = exact - res_in.z;
  end

  // A stage moves when any stage downstream of it has room.
  always_comb begin
    logic down;
    down = 1'b0;
    adv  = '0;
    rdy  = '0;
    for (int s = 0; s < STAGES; s++) begin
      down = bus.out_ready;
      for (int t = STAGES - 1; t > s; t--) begin
        down = down | ~vld[t];
      end
      adv[s] = vld[s] & down;
      rdy[s] = ~vld[s] | down;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic load;
    res_t d;
    logic v;
    res_t q;

    if (s == 0) begin : g_head
      assign load = bus.in_valid & rdy[0];
      assign d    = res_in;
    end else begin : g_body
      assign load = adv[s-1];
      assign d    = st[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v <= 1'b0;
        q <= '0;
      end else if (load) begin
        v <= 1'b1;
        q <= d;
      end else if (adv[s]) begin
        v <= 1'b0;
      end
    end

    assign vld[s] = v;
    assign st[s]  = q;
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.z         = st[STAGES-1].z;
  assign bus.err       = st[STAGES-1].err;
  assign bus.out_mode  = st[STAGES-1].mode;

  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_cnt <= '0;
    end else if (stat_clr) begin
      inexact_cnt <= '0;
    end else if (out_fire && (|bus.err) && !(&inexact_cnt)) begin
      inexact_cnt <= inexact_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed + random scoreboard bench for approx_mult_pipe
// (WIDTH=8, TRUNC_COLS=6, APPROX_COLS=8, STAGES=2, CNT_W=2).
module tb_approx_mult_pipe;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam int CW = 2;

  typedef struct {
    logic [15:0] z;
    logic [15:0] err;
    logic        m;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          stat_clr;
  logic [CW-1:0] inexact_cnt;

  approx_mult_if #(.WIDTH(W)) bus ();

  approx_mult_pipe #(
    .WIDTH(W), .TRUNC_COLS(6), .APPROX_COLS(8),
    .STAGES(ST), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stat_clr(stat_clr),
    .inexact_cnt(inexact_cnt)
  );

  int   checks;
  int   failures;
  int   cyc;
  int   cnt_exp;
  bit   rec;
  exp_t exp_q [$];
  int   fire_cyc [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Independent column model: gather each column's bits, then reduce.
  function automatic logic [15:0] model_z(
    input logic [7:0] a, input logic [7:0] b, input logic m
  );
    int unsigned total;
    bit          bits [$];
    int          v;
    total = 0;
    if (!m) return 16'(a * b);
    for (int c = 0; c < 16; c++) begin
      bits.delete();
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          if (i + j == c) bits.push_back(a[i] & b[j]);
      if (c >= 8) begin
        foreach (bits[k]) total += int'(bits[k]) << c;
      end else if (c >= 6) begin
        for (int k = 0; k < bits.size(); k += 2) begin
          if (k + 1 < bits.size()) v = bits[k] | bits[k+1];
          else v = bits[k];
          total += v << c;
        end
      end
    end
    return total[15:0];
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic m, input logic [15:0] ez,
                      input logic [15:0] ee);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.mode = m;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.z = ez;
        e.err = ee;
        e.m = m;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        timeout("send_accept");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand();
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] z;
    a = 8'($urandom);
    b = 8'($urandom);
    m = 1'($urandom_range(0, 1));
    z = model_z(a, b, m);
    send(a, b, m, z, 16'(a * b) - z);
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      n++;
      if (n > 100) begin
        timeout("drain");
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard.
  initial begin : monitor
    bit          held;
    logic [15:0] hz;
    logic [15:0] he;
    logic        hm;
    exp_t        e;
    held = 0;
    hz = '0;
    he = '0;
    hm = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        chk("inexact_cnt", 32'(inexact_cnt), cnt_exp);
        if (held && bus.out_valid) begin
          chk("hold_z", bus.z, hz);
          chk("hold_err", bus.err, he);
          chk("hold_mode", bus.out_mode, hm);
        end
        held = bus.out_valid && !bus.out_ready;
        hz = bus.z;
        he = bus.err;
        hm = bus.out_mode;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_output observed=%0h expected=none",
                   bus.z);
          end else begin
            e = exp_q.pop_front();
            chk("z", bus.z, e.z);
            chk("err", bus.err, e.err);
            chk("out_mode", bus.out_mode, e.m);
            if (rec) fire_cyc.push_back(cyc);
            if (e.err != 0 && cnt_exp < 3) cnt_exp++;
          end
        end
        if (stat_clr) cnt_exp = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int acc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        m;
    logic [15:0] z;
    exp_t        e;
    checks = 0;
    failures = 0;
    cyc = 0;
    cnt_exp = 0;
    rec = 0;
    rst = 1'b1;
    stat_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.mode = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_z", bus.z, 16'h0);
    chk("rst_err", bus.err, 16'h0);
    chk("rst_cnt", 32'(inexact_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // OR loss plus truncation, then exact mode
    send(8'h03, 8'h60, 1'b1, 16'd192, 16'd96);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_after_or", 32'(inexact_cnt), 1);
    send(8'h03, 8'h60, 1'b0, 16'd288, 16'd0);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_after_exact", 32'(inexact_cnt), 1);

    // truncation only, exact high column
    send(8'd3, 8'd3, 1'b1, 16'd0, 16'd9);
    send(8'h80, 8'h80, 1'b1, 16'h4000, 16'd0);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_after_trunc", 32'(inexact_cnt), 2);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("cnt_clr", 32'(inexact_cnt), 0);

    // latency: edges from presenting operands to out_valid
    a = 8'($urandom);
    b = 8'($urandom);
    m = 1'b1;
    z = model_z(a, b, m);
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.mode = m;
    chk("lat_in_ready", bus.in_ready, 1'b1);
    e.z = z;
    e.err = 16'(a * b) - z;
    e.m = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (n > 20) break;
      @(posedge clk);
      n++;
    end
    chk("latency", n, ST);
    drain();

    // back-to-back throughput
    fire_cyc.delete();
    rec = 1;
    repeat (10) send_rand();
    bus.in_valid = 1'b0;
    drain();
    rec = 0;
    chk("tput_count", fire_cyc.size(), 10);
    if (fire_cyc.size() == 10)
      chk("tput_span", fire_cyc[9] - fire_cyc[0], 9);

    // backpressure
    bus.out_ready = 1'b0;
    acc = 0;
    a = 8'($urandom);
    b = 8'($urandom);
    m = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.mode = m;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n = 0;
      if (bus.in_ready) begin
        z = model_z(a, b, m);
        e.z = z;
        e.err = 16'(a * b) - z;
        e.m = m;
        exp_q.push_back(e);
        acc++;
        n = 1;
      end
      @(posedge clk);
      #1;
      if (n == 1) begin
        a = 8'($urandom);
        b = 8'($urandom);
        m = 1'($urandom_range(0, 1));
        bus.x = a;
        bus.y = b;
        bus.mode = m;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", acc, ST);
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // reset with results in flight
    send(8'd3, 8'd3, 1'b1, 16'd0, 16'd9);
    bus.in_valid = 1'b0;
    drain();
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_cnt", 32'(inexact_cnt), 0);
    chk("mid_rst_z", bus.z, 16'h0);
    exp_q.delete();
    cnt_exp = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1'b1);
    chk("rel_out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    repeat (3) send_rand();
    bus.in_valid = 1'b0;
    drain();

    // saturation and clear priority
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    repeat (5) send(8'd3, 8'd3, 1'b1, 16'd0, 16'd9);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_sat", 32'(inexact_cnt), 3);
    bus.out_ready = 1'b0;
    send(8'd3, 8'd3, 1'b1, 16'd0, 16'd9);
    bus.in_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      n++;
      if (n > 20) begin
        timeout("sat_out_valid");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    chk("cnt_clr_wins", 32'(inexact_cnt), 0);
    chk("queue_empty", exp_q.size(), 0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
